// File: rtl/systolic_seq.sv
// Operand sequencer for a 4x4 output-stationary MAC array: clear, skewed feed, flush, capture.
// Optional macro SEQ_ACCUM_EN adds an `accumulate` input that skips the clear for K-tiling.
module systolic_seq #(
    parameter int DATA_W       = 8,
    parameter int ACC_W        = 16,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [16*DATA_W-1:0]  a_mat,
    input  logic [16*DATA_W-1:0]  b_mat,
`ifdef SEQ_ACCUM_EN
    input  logic                  accumulate,
`endif
    input  logic [16*ACC_W-1:0]   arr_data,
    output logic                  busy,
    output logic                  done,
    output logic [16*ACC_W-1:0]   result,
    output logic                  arr_we,
    output logic                  arr_clr,
    output logic [4*DATA_W-1:0]   arr_a_in,
    output logic [4*DATA_W-1:0]   arr_b_in,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_CAPTURE} state_t;

    localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
    localparam logic [FC_W-1:0] FC_LAST = (FLUSH_CYCLES > 0) ? FC_W'(FLUSH_CYCLES - 1) : '0;

    state_t                state, state_n;
    logic [2:0]            t, t_n;
    logic [FC_W-1:0]       fcnt, fcnt_n;
    logic [16*DATA_W-1:0]  a_reg, b_reg, a_src, b_src;
    logic [4*DATA_W-1:0]   a_bus_n, b_bus_n;
    logic                  busy_n, done_n, we_n, clr_n, feed_n, load, cap;
    logic                  accum_sel;

`ifdef SEQ_ACCUM_EN
    assign accum_sel = accumulate;
`else
    assign accum_sel = 1'b0;
`endif

    assign state_dbg = state;

    // Every registered output is computed for the state being entered, so it holds for that whole state.
    always_comb begin
        state_n = state;
        t_n     = t;
        fcnt_n  = fcnt;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        we_n    = 1'b0;
        clr_n   = 1'b0;
        feed_n  = 1'b0;
        load    = 1'b0;
        cap     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load   = 1'b1;
                    busy_n = 1'b1;
                    t_n    = '0;
                    if (accum_sel) begin
                        state_n = S_FEED;
                        we_n    = 1'b1;
                        feed_n  = 1'b1;
                    end else begin
                        state_n = S_CLEAR;
                        clr_n   = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                state_n = S_FEED;
                t_n     = '0;
                busy_n  = 1'b1;
                we_n    = 1'b1;
                feed_n  = 1'b1;
            end
            S_FEED: begin
                busy_n = 1'b1;
                if (t == 3'd6) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_n = S_CAPTURE;
                    end else begin
                        state_n = S_FLUSH;
                        fcnt_n  = '0;
                        we_n    = 1'b1;
                    end
                end else begin
                    t_n    = t + 3'd1;
                    we_n   = 1'b1;
                    feed_n = 1'b1;
                end
            end
            S_FLUSH: begin
                busy_n = 1'b1;
                if (fcnt == FC_LAST) begin
                    state_n = S_CAPTURE;
                end else begin
                    fcnt_n = fcnt + FC_W'(1);
                    we_n   = 1'b1;
                end
            end
            S_CAPTURE: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
                cap     = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
            t_n     = '0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            we_n    = 1'b0;
            clr_n   = 1'b0;
            feed_n  = 1'b0;
            cap     = 1'b0;
        end
    end

    // The first feed step can be issued straight from IDLE, before the operand registers load.
    always_comb begin
        a_src   = (state == S_IDLE) ? a_mat : a_reg;
        b_src   = (state == S_IDLE) ? b_mat : b_reg;
        a_bus_n = '0;
        b_bus_n = '0;
        if (feed_n) begin
            for (int l = 0; l < 4; l++) begin
                if (int'(t_n) - l >= 0 && int'(t_n) - l <= 3) begin
                    a_bus_n[DATA_W*l +: DATA_W] = a_src[DATA_W*(4*l + int'(t_n) - l) +: DATA_W];
                    b_bus_n[DATA_W*l +: DATA_W] = b_src[DATA_W*(4*(int'(t_n) - l) + l) +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            t        <= '0;
            fcnt     <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            arr_we   <= 1'b0;
            arr_clr  <= 1'b0;
            arr_a_in <= '0;
            arr_b_in <= '0;
        end else begin
            state    <= state_n;
            t        <= t_n;
            fcnt     <= fcnt_n;
            busy     <= busy_n;
            done     <= done_n;
            arr_we   <= we_n;
            arr_clr  <= clr_n;
            arr_a_in <= a_bus_n;
            arr_b_in <= b_bus_n;
            if (load) begin
                a_reg <= a_mat;
                b_reg <= b_mat;
            end
            if (cap) begin
                result <= arr_data;
            end
        end
    end

endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq: a behavioural 4x4 MAC array closes the loop; results are checked
// against a plain matrix product, and per-cycle control/bus values against the tile timeline.
module tb_systolic_seq;
    localparam int DATA_W       = 8;
    localparam int ACC_W        = 16;
    localparam int FLUSH_CYCLES = 3;
    localparam int RW           = 16 * ACC_W;
    localparam int MW           = 16 * DATA_W;

    logic               clk = 1'b0;
    logic               rst, start, abort;
    logic [MW-1:0]      a_mat, b_mat;
`ifdef SEQ_ACCUM_EN
    logic               accumulate;
`endif
    logic [RW-1:0]      arr_data;
    logic               busy, done, arr_we, arr_clr;
    logic [RW-1:0]      result;
    logic [4*DATA_W-1:0] arr_a_in, arr_b_in;
    logic [2:0]         state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    int prev_c [4][4];
    logic [RW-1:0] last_result;
    logic [MW-1:0] ta, tb2, ones;
    logic seen;

    always #5 clk = ~clk;

    systolic_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_mat(a_mat), .b_mat(b_mat),
`ifdef SEQ_ACCUM_EN
        .accumulate(accumulate),
`endif
        .arr_data(arr_data), .busy(busy), .done(done), .result(result),
        .arr_we(arr_we), .arr_clr(arr_clr), .arr_a_in(arr_a_in), .arr_b_in(arr_b_in),
        .state_dbg(state_dbg)
    );

    // Behavioural output-stationary array: a flows right, b flows down, each PE accumulates a*b.
    logic [ACC_W-1:0]  acc [4][4];
    logic [DATA_W-1:0] ar  [4][4];
    logic [DATA_W-1:0] br  [4][4];
    logic arr_rst_n;
    assign arr_rst_n = ~arr_clr & ~rst;

    function automatic logic [DATA_W-1:0] a_at(int i, int j);
        return (j == 0) ? arr_a_in[DATA_W*i +: DATA_W] : ar[i][j-1];
    endfunction
    function automatic logic [DATA_W-1:0] b_at(int i, int j);
        return (i == 0) ? arr_b_in[DATA_W*j +: DATA_W] : br[i-1][j];
    endfunction

    always @(posedge clk or negedge arr_rst_n) begin
        if (!arr_rst_n) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    acc[i][j] <= '0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end
        end else if (arr_we) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    acc[i][j] <= acc[i][j] + ACC_W'(a_at(i, j)) * ACC_W'(b_at(i, j));
                    ar[i][j]  <= a_at(i, j);
                    br[i][j]  <= b_at(i, j);
                end
        end
    end

    always_comb begin
        arr_data = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                arr_data[ACC_W*(15 - (4*i + j)) +: ACC_W] = acc[i][j];
    end

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] rand_mat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One tile from start to the done cycle; returns sampling inside the done cycle.
    // extra > 0 pulses start during that busy cycle, which must be ignored.
    task automatic run_tile(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit acc_en, input int extra);
        int am [4][4];
        int bm [4][4];
        int ec [4][4];
        int off, last, t;
        logic [4*DATA_W-1:0] ea, eb;
        logic [RW-1:0] er;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                am[r][c] = int'(a[DATA_W*(4*r + c) +: DATA_W]);
                bm[r][c] = int'(b[DATA_W*(4*r + c) +: DATA_W]);
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ec[i][j] = acc_en ? prev_c[i][j] : 0;
                for (int k = 0; k < 4; k++) ec[i][j] += am[i][k] * bm[k][j];
            end
        off  = acc_en ? 1 : 0;
        last = 13 - off;
        start = 1'b1;
        a_mat = a;
        b_mat = b;
`ifdef SEQ_ACCUM_EN
        accumulate = acc_en;
`endif
        @(negedge clk);
        start = 1'b0;
        a_mat = rand_mat();
        b_mat = rand_mat();
        for (int n = 1; n <= last; n++) begin
            if (n > 1) @(negedge clk);
            t  = n - 2 + off;
            ea = '0;
            eb = '0;
            if (t >= 0 && t <= 6) begin
                for (int l = 0; l < 4; l++) begin
                    if (t - l >= 0 && t - l <= 3) begin
                        ea[DATA_W*l +: DATA_W] = DATA_W'(am[l][t-l]);
                        eb[DATA_W*l +: DATA_W] = DATA_W'(bm[t-l][l]);
                    end
                end
            end
            check($sformatf("busy@%0d", n), busy, n < last);
            check($sformatf("done@%0d", n), done, n == last);
            check($sformatf("arr_clr@%0d", n), arr_clr, !acc_en && n == 1);
            check($sformatf("arr_we@%0d", n), arr_we, t >= 0 && t <= 6 + FLUSH_CYCLES);
            check($sformatf("arr_a_in@%0d", n), arr_a_in, ea);
            check($sformatf("arr_b_in@%0d", n), arr_b_in, eb);
            start = (n == extra);
        end
        start = 1'b0;
        er = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                er[ACC_W*(15 - (4*i + j)) +: ACC_W] = ACC_W'(ec[i][j]);
        check("result", result, er);
        last_result = er;
        prev_c = ec;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; a_mat = '0; b_mat = '0;
`ifdef SEQ_ACCUM_EN
        accumulate = 1'b0;
`endif
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) prev_c[i][j] = 0;
        last_result = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_we", arr_we, 0);
        check("rst_clr", arr_clr, 0);
        check("rst_a_in", arr_a_in, 0);
        check("rst_b_in", arr_b_in, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Identity times B gives B back.
        ta = '0; tb2 = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ta[DATA_W*(4*r + c) +: DATA_W]  = (r == c) ? DATA_W'(1) : DATA_W'(0);
                tb2[DATA_W*(4*r + c) +: DATA_W] = DATA_W'(4*r + c + 1);
            end
        run_tile(ta, tb2, 1'b0, 0);
        @(negedge clk);

        for (int e = 0; e < 16; e++) ones[DATA_W*e +: DATA_W] = DATA_W'(1);
        run_tile(ones, ones, 1'b0, 0);
        @(negedge clk);

        // Start pulsed mid-tile is ignored; a start in the done cycle is taken back-to-back.
        run_tile(rand_mat(), rand_mat(), 1'b0, 5);
        run_tile(rand_mat(), rand_mat(), 1'b0, 0);
        @(negedge clk);
        check("after_done", done, 0);

`ifdef SEQ_ACCUM_EN
        run_tile(ones, ones, 1'b0, 0);
        @(negedge clk);
        run_tile(ones, ones, 1'b1, 0);
        @(negedge clk);
        run_tile(rand_mat(), rand_mat(), 1'b1, 0);
        @(negedge clk);
`endif

        // Abort during FEED t=2.
        start = 1'b1; a_mat = rand_mat(); b_mat = rand_mat();
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_we", arr_we, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_we", arr_we, 0);
        check("abort_a_in", arr_a_in, 0);
        check("abort_b_in", arr_b_in, 0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        check("abort_result", result, last_result);

        run_tile(rand_mat(), rand_mat(), 1'b0, 0);
        @(negedge clk);

        // Asynchronous reset in FLUSH.
        start = 1'b1; a_mat = rand_mat(); b_mat = rand_mat();
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_we", arr_we, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_we", arr_we, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_a_in", arr_a_in, 0);
        check("arst_b_in", arr_b_in, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) prev_c[i][j] = 0;
        @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            run_tile(rand_mat(), rand_mat(), 1'b0, 0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/systolic_seq.md
# systolic_seq

Sequencer for the 4x4 output-stationary MAC array. It captures two 4x4 operand matrices on a start handshake, clears the array accumulators, and streams the operands into the array edge buses with the diagonal skew. It then flushes the pipeline, latches the 16 accumulated results, and signals completion. It sits between the host/buffer logic and the array instance, driving the array's write-enable, edge inputs and accumulator clear.

## Interface

**Parameters**
- `DATA_W`, 8, operand element width.
- `ACC_W`, 16, accumulator width per PE.
- `FLUSH_CYCLES`, 3, cycles with `arr_we=1` and zero inputs after the last operand injection (array depth − 1).

**Ports**
- `clk` in 1: the single clock; everything is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a tile; sampled only in IDLE.
- `abort` in 1: abandon the current tile.
- `a_mat` in 16·DATA_W: element A[i][k] at bits [DATA_W·(4i+k) +: DATA_W].
- `b_mat` in 16·DATA_W: element B[k][j] at bits [DATA_W·(4k+j) +: DATA_W].
- `busy` out 1: high from the cycle after an accepted start until the done cycle (exclusive).
- `done` out 1: one-cycle pulse when `result` is valid.
- `result` out 16·ACC_W: copy of `arr_data`, latched at capture and held until the next capture.
- `arr_we` out 1: array MAC enable.
- `arr_clr` out 1: accumulator clear pulse. Top level drives the array's active-low reset from `~arr_clr & ~rst`.
- `arr_a_in` out 4·DATA_W: lane i feeds row i.
- `arr_b_in` out 4·DATA_W: lane j feeds column j.
- `arr_data` in 16·ACC_W: array result bus, C00 in the MSBs.
- `accumulate` in 1: present only with `SEQ_ACCUM_EN`.

## Operation

**States:** IDLE, CLEAR, FEED, FLUSH, CAPTURE.

- **IDLE:** `start=1` latches `a_mat`/`b_mat` into internal registers and moves to CLEAR.
- **CLEAR:** 1 cycle, `arr_clr=1`, `arr_we=0`, edge buses 0. Then goes to FEED with step counter t=0.
- **FEED:** 7 cycles, t=0..6, `arr_we=1`.
  - Lane i of `arr_a_in` = A[i][t−i] if 0 ≤ t−i ≤ 3, else 0.
  - Lane j of `arr_b_in` = B[t−j][j] if 0 ≤ t−j ≤ 3, else 0.
  - Leaves for FLUSH after t=6.
- **FLUSH:** `FLUSH_CYCLES` cycles, `arr_we=1`, edge buses 0.
- **CAPTURE:** 1 cycle, `arr_we=0`. `result <= arr_data` at the end of the cycle. Next state is IDLE, with `done=1` in that first IDLE cycle.

**Rules:**
- All `arr_*` outputs and `busy`/`done` are registered; each value is stable for the whole state cycle.
- The block performs no arithmetic. Operand and result bits pass through unmodified.
- `start` while `busy=1` is ignored; no queueing.
- `start=1` in the done cycle is accepted, giving back-to-back tiles.
- `abort=1` in any non-IDLE state goes to IDLE on the next edge:
  - `arr_we=0`, buses 0, `busy=0`;
  - no `done`, `result` unchanged.
- If `abort` and `start` are both high in IDLE, `start` wins and `abort` is ignored.
- Asserting `rst` at any time, including mid-tile, forces IDLE immediately.

**Reset values:** `busy=0`, `done=0`, `result=0`, `arr_we=0`, `arr_clr=0`, `arr_a_in=0`, `arr_b_in=0`, operand registers 0.

## Timing

- Start is sampled in cycle 0.
- Cycle 1: CLEAR.
- Cycles 2–8: FEED.
- Cycles 9 to 8+`FLUSH_CYCLES`: FLUSH.
- Next cycle: CAPTURE.
- The following cycle: `done=1`.
- Default latency is start → done = 13 cycles; a new tile can start every 13 cycles.
- `busy` is high in cycles 1–12 (defaults).

## Configuration

`SEQ_ACCUM_EN`:
- **Defined:**
  - The `accumulate` port exists and is sampled with `start`.
  - If `accumulate=1`, CLEAR is skipped: IDLE goes straight to FEED and `arr_clr` stays 0. Results add onto the previous tile, for K-dimension tiling.
  - Latency becomes 12 cycles.
- **Undefined:** the port is absent and every tile clears.

## Test plan

- A = identity, B[k][j] = 4k+j+1 → `done` exactly 13 cycles after start; `result` Cij = B[i][j] (C00=1, C33=16).
- A = B = all ones → every Cij = 4. Check `busy` high for exactly 12 cycles and `arr_clr` high only in cycle 1.
- Skew check: monitor the edge buses during FEED. At t=3 `arr_a_in` = {A[3][0], A[2][1], A[1][2], A[0][3]} (lane 3 first); at t=6 only lane 3 is nonzero (= A[3][3], B[3][3]).
- `start` pulsed in cycle 5 of a busy tile → ignored, single `done`. `start` in the done cycle → second tile's `done` 13 cycles later.
- `abort` in FEED t=2 → IDLE next cycle, `arr_we=0`, no `done`, `result` retains its prior value. `rst` asserted in FLUSH → all outputs 0 asynchronously.
- With `SEQ_ACCUM_EN`: all-ones tile, then a tile with `accumulate=1` → Cij = 8, no `arr_clr` pulse, latency 12.
